// File: rtl/debug_pbus_axil_master_if.sv
// Signal bundle between the debug bridge's system port, this responder, and the AXI4-Lite fabric.
// modport master: the responder's view (PBUS responder, AXI master). modport slave: bridge plus fabric.
interface debug_pbus_axil_master_if;
  logic        PVALID;
  logic        PREADY;
  logic [3:0]  PWSTB;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PERR;

  logic        M_AWVALID, M_AWREADY;
  logic [31:0] M_AWADDR;
  logic [2:0]  M_AWPROT;
  logic        M_WVALID, M_WREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_BVALID, M_BREADY;
  logic [1:0]  M_BRESP;
  logic        M_ARVALID, M_ARREADY;
  logic [31:0] M_ARADDR;
  logic [2:0]  M_ARPROT;
  logic        M_RVALID, M_RREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  modport master (
    input  PVALID, PWSTB, PADDR, PWDATA,
    output PREADY, PRDATA, PERR,
    output M_AWVALID, M_AWADDR, M_AWPROT, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    output M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_ARREADY, M_RVALID, M_RDATA, M_RRESP
  );

  modport slave (
    output PVALID, PWSTB, PADDR, PWDATA,
    input  PREADY, PRDATA, PERR,
    input  M_AWVALID, M_AWADDR, M_AWPROT, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    input  M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_ARREADY, M_RVALID, M_RDATA, M_RRESP
  );
endinterface

// File: rtl/debug_pbus_axil_master.sv
// Debug PBUS responder: one debug access at a time turned into one AXI4-Lite transaction.
// Optional DEBUG_PBUS_TIMEOUT_EN adds a handshake watchdog that forces an error completion.
module debug_pbus_axil_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter logic [2:0]  AXI_PROT       = 3'b010
) (
  input logic                       CLK,
  input logic                       RST_N,
  debug_pbus_axil_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, DONE} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  logic        awvalid, wvalid, bready, arvalid, rready, pready, perr;
  logic [31:0] addr_q, data_q, prdata;
  logic [3:0]  strb_q;

  assign bus.M_AWVALID = awvalid;
  assign bus.M_AWADDR  = addr_q;
  assign bus.M_AWPROT  = AXI_PROT;
  assign bus.M_WVALID  = wvalid;
  assign bus.M_WDATA   = data_q;
  assign bus.M_WSTRB   = strb_q;
  assign bus.M_BREADY  = bready;
  assign bus.M_ARVALID = arvalid;
  assign bus.M_ARADDR  = addr_q;
  assign bus.M_ARPROT  = AXI_PROT;
  assign bus.M_RREADY  = rready;
  assign bus.PREADY    = pready;
  assign bus.PRDATA    = prdata;
  assign bus.PERR      = perr;

`ifdef DEBUG_PBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit, resp_done;

  assign tmo_hit   = (state inside {WREQ, WRESP, RREQ, RDATA}) &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign resp_done = (state == WRESP && bus.M_BVALID) || (state == RDATA && bus.M_RVALID);

  // Zero in IDLE/DONE, so every WREQ/RREQ entry starts counting from 0.
  always_ff @(posedge CLK) begin
    if (!RST_N || state == IDLE || state == DONE) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      pready  <= 1'b0;
      perr    <= 1'b0;
      prdata  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.PVALID) begin
          addr_q <= bus.PADDR;
          data_q <= bus.PWDATA;
          strb_q <= bus.PWSTB;
          if (|bus.PWSTB) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WREQ;
          end else begin
            arvalid <= 1'b1;
            state   <= RREQ;
          end
        end
        WREQ: begin
          // AW and W retire independently; a dropped VALID marks that channel done.
          if (bus.M_AWREADY) awvalid <= 1'b0;
          if (bus.M_WREADY)  wvalid  <= 1'b0;
          if (!(awvalid && !bus.M_AWREADY) && !(wvalid && !bus.M_WREADY)) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: if (bus.M_BVALID) begin
          bready <= 1'b0;
          perr   <= |bus.M_BRESP;
          pready <= 1'b1;
          state  <= DONE;
        end
        RREQ: if (bus.M_ARREADY) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= RDATA;
        end
        RDATA: if (bus.M_RVALID) begin
          rready <= 1'b0;
          prdata <= (bus.M_RRESP == 2'b00) ? bus.M_RDATA : ERR_RDATA;
          perr   <= |bus.M_RRESP;
          pready <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          pready <= 1'b0;
          perr   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef DEBUG_PBUS_TIMEOUT_EN
      // Watchdog overrides the case above unless the final response lands this cycle.
      if (tmo_hit && !resp_done) begin
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
        perr    <= 1'b1;
        pready  <= 1'b1;
        if (state inside {RREQ, RDATA}) prdata <= ERR_RDATA;
        state   <= DONE;
      end
`endif
    end
  end

endmodule
